// File: rtl/flash_arb_pkg.sv
// rtl/flash_arb_pkg.sv - shared state type and default widths for the flash read arbiter
package flash_arb_pkg;

  localparam int FLASH_ADDR_W = 20;
  localparam int FLASH_DATA_W = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    WAIT    = 2'd2,
    RELEASE = 2'd3
  } arbState_t;

endpackage

// File: rtl/flash_read_arbiter_rr_pick.sv
// rtl/flash_read_arbiter_rr_pick.sv - combinational round-robin first-set picker
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] pointer,
  output logic          valid,
  output logic [IW-1:0] index
);

  int cand;

  // Scan upward from the pointer, wrapping at N, and keep the first requester found.
  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = 0;
    for (int i = 0; i < N; i++) begin
      cand = (int'(pointer) + i) % N;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/flash_read_arbiter.sv
// rtl/flash_read_arbiter.sv - round-robin arbiter for the shared flash read port; FLASH_RD_TIMEOUT_EN adds a WAIT watchdog
module flash_read_arbiter
  import flash_arb_pkg::*;
#(
  parameter int NREQ        = 3,
  parameter int ADDR_W      = FLASH_ADDR_W,
  parameter int DATA_W      = FLASH_DATA_W,
  parameter int TIMEOUT_CYC = 4096,
  localparam int GW         = $clog2(NREQ)
) (
  input  logic                   iCLK,
  input  logic                   iRST,
  input  logic                   iWrite_Done,
  input  logic [NREQ-1:0]        iREQ,
  input  logic [NREQ*ADDR_W-1:0] iADDR,
  output logic [DATA_W-1:0]      oDATA,
  output logic [NREQ-1:0]        oREADY,
  output logic                   oERR,
  output logic [GW-1:0]          oGRANT,
  output logic                   oBUSY,
  output logic                   oFLASH_REQ,
  output logic [ADDR_W-1:0]      oFLASH_ADDR,
  input  logic [DATA_W-1:0]      iFLASH_DATA,
  input  logic                   iFLASH_READY
);

  arbState_t     state;
  logic [GW-1:0] rrPtr;
  logic          pickValid;
  logic [GW-1:0] pickIdx;
  logic          flashAccept;
  logic          timeoutHit;

  rr_pick #(
    .N  (NREQ),
    .IW (GW)
  ) uPick (
    .req     (iREQ),
    .pointer (rrPtr),
    .valid   (pickValid),
    .index   (pickIdx)
  );

  // Flash data is only trusted while a read is outstanding; strays elsewhere are dropped.
  assign flashAccept = (state == WAIT) && iFLASH_READY;

`ifdef FLASH_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] waitCnt;

  // Count WAIT cycles since the strobe; the last allowed cycle forces an error completion.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      waitCnt <= '0;
    end else if (state == ISSUE) begin
      waitCnt <= '0;
    end else if (state == WAIT) begin
      waitCnt <= waitCnt + 1'b1;
    end
  end

  assign timeoutHit = (state == WAIT) && !iFLASH_READY &&
                      (waitCnt == CNT_W'(TIMEOUT_CYC - 1));

  // Error flag qualifies each completion pulse and holds alongside oDATA.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      oERR <= 1'b0;
    end else if (flashAccept) begin
      oERR <= 1'b0;
    end else if (timeoutHit) begin
      oERR <= 1'b1;
    end
  end
`else
  // Without the watchdog the limit is meaningless; keep the parameter list identical across builds.
  if (TIMEOUT_CYC < 1) begin : gTimeoutUnused
  end

  assign timeoutHit = 1'b0;
  assign oERR       = 1'b0;
`endif

  // Sequence one flash read at a time and register the completion towards the requesters.
  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state       <= IDLE;
      rrPtr       <= '0;
      oGRANT      <= '0;
      oFLASH_ADDR <= '0;
      oDATA       <= '0;
      oREADY      <= '0;
    end else begin
      oREADY <= '0;
      case (state)
        IDLE: begin
          if (iWrite_Done && pickValid) begin
            oGRANT      <= pickIdx;
            oFLASH_ADDR <= iADDR[int'(pickIdx)*ADDR_W +: ADDR_W];
            state       <= ISSUE;
          end
        end
        ISSUE: begin
          rrPtr <= (int'(oGRANT) == NREQ - 1) ? '0 : oGRANT + 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (flashAccept || timeoutHit) begin
            oDATA  <= flashAccept ? iFLASH_DATA : {DATA_W{1'b1}};
            oREADY <= NREQ'(1) << oGRANT;
            state  <= RELEASE;
          end
        end
        RELEASE: begin
          // iREQ is deliberately ignored here so a requester still lowering it is not served twice.
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign oBUSY      = (state != IDLE);
  assign oFLASH_REQ = (state == ISSUE);

endmodule

// File: tb/tb_flash_read_arbiter.sv
// tb/tb_flash_read_arbiter.sv - scoreboard bench for flash_read_arbiter with a flash model and random requesters
module tb_flash_read_arbiter;

  localparam int NREQ   = 3;
  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;
  localparam int TOUT   = 16;
  localparam int GW     = $clog2(NREQ);

  logic                   iCLK = 1'b0;
  logic                   iRST = 1'b0;
  logic                   iWrite_Done = 1'b0;
  logic [NREQ-1:0]        iREQ = '0;
  logic [NREQ*ADDR_W-1:0] iADDR = '0;
  logic [DATA_W-1:0]      oDATA;
  logic [NREQ-1:0]        oREADY;
  logic                   oERR;
  logic [GW-1:0]          oGRANT;
  logic                   oBUSY;
  logic                   oFLASH_REQ;
  logic [ADDR_W-1:0]      oFLASH_ADDR;
  logic [DATA_W-1:0]      iFLASH_DATA = '0;
  logic                   iFLASH_READY = 1'b0;

  flash_read_arbiter #(
    .NREQ        (NREQ),
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .TIMEOUT_CYC (TOUT)
  ) dut (
    .iCLK         (iCLK),
    .iRST         (iRST),
    .iWrite_Done  (iWrite_Done),
    .iREQ         (iREQ),
    .iADDR        (iADDR),
    .oDATA        (oDATA),
    .oREADY       (oREADY),
    .oERR         (oERR),
    .oGRANT       (oGRANT),
    .oBUSY        (oBUSY),
    .oFLASH_REQ   (oFLASH_REQ),
    .oFLASH_ADDR  (oFLASH_ADDR),
    .iFLASH_DATA  (iFLASH_DATA),
    .iFLASH_READY (iFLASH_READY)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [NREQ-1:0]   mask;
    logic [DATA_W-1:0] data;
    logic              err;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;

  // flash model knobs, written by the stimulus process only
  int                flashLat    = 3;
  logic              useFixed    = 1'b0;
  logic [DATA_W-1:0] fixedData   = '0;
  logic              flashSilent = 1'b0;

  // flash model / reference model state
  int                modelPtr = 0;
  int                pending  = 0;
  int                strobes  = 0;
  logic [DATA_W-1:0] pendData = '0;
  int                g;
  int                c;
  exp_t              newExp;

  int readies  = 0;
  int cycleCnt = 0;
  exp_t got;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic logic [ADDR_W-1:0] newAddr(input int k);
    return {4'(k), 16'($urandom)};
  endfunction

  always @(posedge iCLK) cycleCnt <= cycleCnt + 1;

  // Flash controller model and grant reference: rotating priority from the last grantee + 1.
  always @(negedge iCLK) begin
    iFLASH_READY = 1'b0;
    if (!iRST) begin
      modelPtr = 0;
      expQ.delete();
    end
    if (pending > 0) begin
      pending = pending - 1;
      if (pending == 0) begin
        iFLASH_READY = 1'b1;
        iFLASH_DATA  = pendData;
      end
    end
    if (iRST && oFLASH_REQ) begin
      strobes++;
      check("single_outstanding", 64'(pending), 0);
      check("write_done_at_grant", 64'(iWrite_Done), 1);
      g = -1;
      for (int j = 0; j < NREQ; j++) begin
        c = (modelPtr + j) % NREQ;
        if (g < 0 && iREQ[c]) g = c;
      end
      if (g < 0) begin
        checks++;
        errors++;
        $display("FAIL grant_without_request: actual=%0d required=none", oGRANT);
      end else begin
        check("grant_index", 64'(oGRANT), 64'(g));
        check("flash_addr", 64'(oFLASH_ADDR), 64'(iADDR[g*ADDR_W +: ADDR_W]));
        modelPtr    = (g + 1) % NREQ;
        newExp.mask = NREQ'(1) << g;
        if (flashSilent) begin
          newExp.data = '1;
          newExp.err  = 1'b1;
        end else begin
          newExp.data = useFixed ? fixedData : DATA_W'($urandom);
          newExp.err  = 1'b0;
          pendData    = newExp.data;
          pending     = (flashLat > 0) ? flashLat : int'($urandom_range(1, 4));
        end
        expQ.push_back(newExp);
      end
    end
  end

  // Monitor: every completion pulse must match the oldest outstanding expectation.
  always @(negedge iCLK) begin
    if (iRST && oREADY != '0) begin
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: actual=%b required=none", oREADY);
      end else begin
        got = expQ.pop_front();
        check("ready_mask", 64'(oREADY), 64'(got.mask));
        check("ready_data", 64'(oDATA), 64'(got.data));
        check("ready_err", 64'(oERR), 64'(got.err));
        readies++;
      end
    end
  end

  task automatic tick();
    @(negedge iCLK);
    #1;
  endtask

  task automatic waitReady(input int target, input int budget, input string name);
    int n = 0;
    while (readies < target && n < budget) begin
      tick();
      n++;
    end
    check({"ready_", name}, 64'(readies >= target), 1);
  endtask

  task automatic waitStrobe(input int target, input int budget, input string name);
    int n = 0;
    while (strobes < target && n < budget) begin
      tick();
      n++;
    end
    check({"strobe_", name}, 64'(strobes >= target), 1);
  endtask

  task automatic waitIdle(input int budget, input string name);
    int n = 0;
    while ((oBUSY || expQ.size() != 0) && n < budget) begin
      tick();
      n++;
    end
    check({"idle_", name}, 64'(oBUSY || expQ.size() != 0), 0);
  endtask

  int s0;
  int r0;
  int t0;

  initial begin
    // reset state
    repeat (3) @(negedge iCLK);
    check("rst_data", 64'(oDATA), 0);
    check("rst_ready", 64'(oREADY), 0);
    check("rst_err", 64'(oERR), 0);
    check("rst_grant", 64'(oGRANT), 0);
    check("rst_busy", 64'(oBUSY), 0);
    check("rst_flash_req", 64'(oFLASH_REQ), 0);
    check("rst_flash_addr", 64'(oFLASH_ADDR), 0);
    #1;
    iRST = 1'b1;

    // image not loaded: requests must not reach the flash
    for (int k = 0; k < NREQ; k++) iADDR[k*ADDR_W +: ADDR_W] = newAddr(k);
    iREQ = '1;
    s0 = strobes;
    repeat (20) tick();
    check("blocked_strobes", 64'(strobes - s0), 0);
    check("blocked_busy", 64'(oBUSY), 0);

    // single directed read from requester 0
    iREQ = '0;
    tick();
    iADDR[0 +: ADDR_W] = 20'h00018;
    useFixed  = 1'b1;
    fixedData = 16'hA5C3;
    flashLat  = 3;
    s0 = strobes;
    r0 = readies;
    iREQ = 3'b001;
    iWrite_Done = 1'b1;
    waitReady(r0 + 1, 50, "single");
    iREQ = '0;
    waitIdle(20, "single");
    check("single_strobe_count", 64'(strobes - s0), 1);
    check("single_data_held", 64'(oDATA), 64'(16'hA5C3));

    // all requesting, latency 1: strict rotation
    useFixed = 1'b0;
    flashLat = 1;
    for (int k = 0; k < NREQ; k++) iADDR[k*ADDR_W +: ADDR_W] = newAddr(k);
    r0 = readies;
    iREQ = '1;
    waitReady(r0 + 6, 200, "rotation");
    iREQ = '0;
    waitIdle(20, "rotation");

    // reset while waiting on flash; the late response must be ignored
    flashLat = 5;
    s0 = strobes;
    iREQ = 3'b010;
    waitStrobe(s0 + 1, 20, "pre_reset");
    tick();
    check("pre_reset_waiting", 64'(oBUSY && !oFLASH_REQ), 1);
    iREQ = '0;
    iRST = 1'b0;
    #1;
    check("async_rst_busy", 64'(oBUSY), 0);
    check("async_rst_addr", 64'(oFLASH_ADDR), 0);
    repeat (2) @(negedge iCLK);
    #1;
    iRST = 1'b1;
    s0 = strobes;
    r0 = readies;
    repeat (8) tick();
    check("stale_ready_count", 64'(readies - r0), 0);
    check("stale_strobes", 64'(strobes - s0), 0);
    check("stale_data", 64'(oDATA), 0);
    flashLat = 2;
    iREQ = '1;
    waitStrobe(s0 + 1, 20, "post_reset");
    check("grant_after_reset", 64'(oGRANT), 0);
    waitReady(r0 + 1, 20, "post_reset");
    iREQ = '0;
    waitIdle(20, "post_reset");

    // requester 2 withdraws right after its grant
    flashLat = 3;
    s0 = strobes;
    r0 = readies;
    iREQ = 3'b101;
    waitStrobe(s0 + 1, 20, "drop");
    check("drop_grant", 64'(oGRANT), 2);
    tick();
    iREQ = 3'b001;
    waitReady(r0 + 1, 20, "drop");
    waitStrobe(s0 + 2, 20, "after_drop");
    check("after_drop_grant", 64'(oGRANT), 0);
    waitReady(r0 + 2, 20, "after_drop");
    iREQ = '0;
    waitIdle(20, "after_drop");

`ifdef FLASH_RD_TIMEOUT_EN
    // flash never answers: watchdog completes with an error, then normal service resumes
    flashSilent = 1'b1;
    s0 = strobes;
    r0 = readies;
    iREQ = 3'b010;
    waitStrobe(s0 + 1, 20, "timeout");
    t0 = cycleCnt;
    waitReady(r0 + 1, 60, "timeout");
    check("timeout_latency", 64'((cycleCnt - t0) >= TOUT && (cycleCnt - t0) <= TOUT + 2), 1);
    flashSilent = 1'b0;
    iREQ = '0;
    tick();
    iREQ = 3'b010;
    waitReady(r0 + 2, 30, "after_timeout");
    iREQ = '0;
    waitIdle(20, "after_timeout");
`endif

    // random requesters, random flash latency and data, occasional write-done drops
    flashLat = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      tick();
      for (int k = 0; k < NREQ; k++) begin
        if (oREADY[k]) begin
          iREQ[k] = ($urandom_range(0, 2) == 0);
          if (iREQ[k]) iADDR[k*ADDR_W +: ADDR_W] = newAddr(k);
        end else if (!iREQ[k] && $urandom_range(0, 3) == 0) begin
          iADDR[k*ADDR_W +: ADDR_W] = newAddr(k);
          iREQ[k] = 1'b1;
        end
      end
      if ($urandom_range(0, 29) == 0) iWrite_Done = ~iWrite_Done;
    end
    iREQ = '0;
    waitIdle(100, "drain");
    check("drain_queue", 64'(expQ.size()), 0);
    check("random_activity", 64'(readies > 20), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1);
  end

endmodule
